// File: rtl/disp_share_arbiter_if.sv
// Handshake bundle between the display requesters and the round-robin display arbiter.
interface disp_share_arbiter_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0]    req;
    logic [32*NSRC-1:0] src_data;
    logic               lock;
    logic [NSRC-1:0]    grant;
    logic               busy;
    logic [31:0]        disp_data;

    modport master (
        output req, src_data, lock,
        input  grant, busy, disp_data
    );

    modport slave (
        input  req, src_data, lock,
        output grant, busy, disp_data
    );
endinterface

// File: rtl/disp_share_arbiter.sv
// Round-robin arbiter time-sharing one 32-bit display word among NSRC requesters,
// holding each grant for DWELL cycles unless the owner drops its request.
module disp_share_arbiter #(
    parameter int NSRC  = 4,
    parameter int DWELL = 100_000_000,
    parameter int CW    = 27
) (
    input  logic               clk,
    input  logic               rst,
    disp_share_arbiter_if.slave bus
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]     disp_data_q, disp_data_d;

    logic [PW-1:0]   win;
    logic            any_req;
    logic            owner_req;
    logic            rearb;
    logic [31:0]     owner_word;

    // First requester at or after ptr, wrapping modulo NSRC.
    function automatic logic [PW-1:0] pick(input logic [NSRC-1:0] r, input logic [PW-1:0] ptr);
        int   idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(ptr) + k) % NSRC;
            if (!found && r[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        if (int'(w) == NSRC - 1) return '0;
        return w + 1'b1;
    endfunction

    function automatic logic [NSRC-1:0] onehot(input logic [PW-1:0] w);
        onehot    = '0;
        onehot[w] = 1'b1;
    endfunction

    assign any_req   = |bus.req;
    assign owner_req = |(bus.req & grant_q);
    assign win       = pick(bus.req, rr_ptr_q);

    // grant_q is one-hot or zero, so OR-ing the masked slices selects the owner's word.
    always_comb begin
        owner_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant_q[i]) owner_word = owner_word | bus.src_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // An owner dropping its request takes priority over dwell expiry and lock.
    always_comb begin
        state_d = state_q;
        rearb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = HOLD;
                    rearb   = 1'b1;
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    if (any_req) rearb   = 1'b1;
                    else         state_d = IDLE;
                end else if (!bus.lock && cnt_q == '0) begin
                    rearb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        disp_data_d = disp_data_q;
        if (state_q == HOLD) disp_data_d = owner_word;
        if (rearb) begin
            grant_d  = onehot(win);
            cnt_d    = CW'(DWELL - 1);
            rr_ptr_d = next_ptr(win);
        end else if (state_d == IDLE) begin
            grant_d = '0;
            cnt_d   = '0;
        end else if (state_q == HOLD && !bus.lock && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            disp_data_q <= '0;
        end else begin
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            disp_data_q <= disp_data_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == HOLD);
    assign bus.disp_data = disp_data_q;
endmodule
